// File: rtl/vga_pkg.sv
// Shared scanout constants and types for the 800x600 display path.
// Timing values are common with the timing generator.
package vga_pkg;

  localparam int HA_END = 800;
  localparam int VA_END = 600;
  localparam int SCREEN = 627;

  localparam int FB_W   = 200;
  localparam int FB_H   = 150;
  localparam int SCALE  = 4;
  localparam int PIX_W  = 4;
  localparam int ADDR_W = 15;

  localparam int SCALE_LG = $clog2(SCALE);
  localparam int LB_AW    = $clog2(FB_W);
  localparam int FB_SIZE  = FB_W * FB_H;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [LB_AW-1:0]  lb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/vga_line_buffer.sv
// One framebuffer row: write port fed by the fetch,
// registered read port feeding the pixel output.
module vga_line_buffer
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [LB_AW-1:0] waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [LB_AW-1:0] raddr,
  output logic [PIX_W-1:0] rdata
);

  localparam lb_addr_t LB_LAST = lb_addr_t'(FB_W - 1);

  pix_t mem [FB_W];

  // Indices past the row only occur during blanking.
  always_ff @(posedge clk) begin
    if (we && waddr <= LB_LAST)
      mem[waddr] <= wdata;
    rdata <= (raddr <= LB_LAST) ? mem[raddr] : '0;
  end

endmodule

// File: rtl/vga_fb_scanout_arbiter.sv
// Framebuffer port arbiter: hblank row fetch into a line buffer,
// draw writes in the gaps, SCALEx replicated scanout.
module vga_fb_scanout_arbiter
  import vga_pkg::*;
(
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              de,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pix,
  output logic              pix_de,
  output logic              busy
);

  localparam logic [9:0] HA_END_C = 10'(HA_END);
  localparam logic [9:0] VA_END_C = 10'(VA_END);
  localparam logic [9:0] SCREEN_C = 10'(SCREEN);
  localparam fb_addr_t   FB_W_A   = fb_addr_t'(FB_W);
  localparam fb_addr_t   FB_SZ_A  = fb_addr_t'(FB_SIZE);
  localparam lb_addr_t   CNT_LAST = lb_addr_t'(FB_W - 1);

  fetch_state_e state, state_d;
  lb_addr_t     cnt, cnt_d, cnt_q;
  fb_addr_t     row_base, row_base_d;
  logic         rd_q;
  logic         de_q;
  logic [9:0]   nl;
  logic         trig;
  pix_t         lb_rdata;

  assign nl = (sy == SCREEN_C) ? '0 : sy + 10'd1;

  assign trig = (state == IDLE)
             && (sx == HA_END_C)
             && (nl < VA_END_C)
             && (nl[SCALE_LG-1:0] == '0);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state    <= IDLE;
      cnt      <= '0;
      cnt_q    <= '0;
      row_base <= '0;
      rd_q     <= 1'b0;
      de_q     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cnt_q    <= cnt;
      row_base <= row_base_d;
      rd_q     <= (state == FETCH);
      de_q     <= de;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    row_base_d = row_base;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    wr_ack     = 1'b0;
    if (!rst_pix) begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            state_d    = FETCH;
            cnt_d      = '0;
            row_base_d = (nl == '0) ? '0 : row_base + FB_W_A;
          end else if (wr_req) begin
            // Out-of-range writes are acked so the drawer never stalls.
            wr_ack    = 1'b1;
            ram_en    = (wr_addr < FB_SZ_A);
            ram_we    = ram_en;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
          end
        end
        FETCH: begin
          ram_en   = 1'b1;
          ram_addr = row_base + fb_addr_t'(cnt);
          cnt_d    = cnt + lb_addr_t'(1);
          if (cnt == CNT_LAST)
            state_d = DRAIN;
        end
        DRAIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy   = !rst_pix && (state != IDLE);
  assign pix_de = de_q;
  assign pix    = de_q ? lb_rdata : '0;

  vga_line_buffer u_lb (
    .clk   (clk_pix),
    .we    (rd_q),
    .waddr (cnt_q),
    .wdata (ram_rdata),
    .raddr (lb_addr_t'(sx >> SCALE_LG)),
    .rdata (lb_rdata)
  );

endmodule
